instr_encode_loader: RTL and testbench

Streams decoded instruction fields into 32-bit instruction words and writes them to instruction memory one word per cycle. It is the encoding counterpart of the immediate generator: a 12-bit immediate is scattered back into the instruction bit positions that the generator extracts it from. It sits between the test/boot host interface and the instruction memory write port, and loads programs into the 8-bit pipeline before execution.

---
 rtl/instr_encode_loader.sv | 118 +++++++++++
 tb/tb_instr_encode_loader.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encode_loader.sv
// ============================================================================
// instr_encode_loader : packs decoded instruction fields into 32-bit words
//                       and streams them into instruction memory.
// Revision: 1.0
// ============================================================================
`default_nettype none

module instr_encode_loader #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [2:0]        in_type_i,
  input  logic [6:0]        in_opcode_i,
  input  logic [4:0]        in_rd_i,
  input  logic [4:0]        in_rs1_i,
  input  logic [4:0]        in_rs2_i,
  input  logic [2:0]        in_funct3_i,
  input  logic [6:0]        in_funct7_i,
  input  logic [11:0]       in_imm_i,
  input  logic              in_last_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  localparam logic [2:0] TYPE_R  = 3'd0;
  localparam logic [2:0] TYPE_I  = 3'd1;
  localparam logic [2:0] TYPE_S  = 3'd2;
  localparam logic [2:0] TYPE_SB = 3'd3;
  localparam logic [2:0] TYPE_UJ = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic [31:0]       wdata_d;
  logic              legal;
  logic              accept;

  // Scatter fields back to the bit positions the immediate generator reads.
  always_comb begin
    wdata_d = '0;
    legal   = 1'b1;
    case (in_type_i)
      TYPE_R:  wdata_d = {in_funct7_i, in_rs2_i, in_rs1_i, in_funct3_i, in_rd_i, in_opcode_i};
      TYPE_I:  wdata_d = {in_imm_i, in_rs1_i, in_funct3_i, in_rd_i, in_opcode_i};
      TYPE_S,
      TYPE_SB: wdata_d = {in_imm_i[11:5], in_rs2_i, in_rs1_i, in_funct3_i,
                          in_imm_i[4:0], in_opcode_i};
      TYPE_UJ: wdata_d = {in_imm_i, 13'b0, in_opcode_i};
      default: legal   = 1'b0;
    endcase
  end

  assign in_ready_o = (state_q == LOAD) && !start_i;
  assign accept     = in_valid_i && in_ready_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      mem_we_q <= 1'b0;
      if (start_i) begin
        state_q <= LOAD;
        addr_q  <= base_addr_i;
      end else if (accept) begin
        if (!legal) begin
          state_q <= ERR;
        end else begin
          mem_we_q    <= 1'b1;
          mem_addr_q  <= addr_q;
          mem_wdata_q <= wdata_d;
          if (in_last_i) begin
            state_q <= DONE;
          end else if (addr_q == LAST_ADDR) begin
            // The final word is kept; only further words are refused.
            state_q <= ERR;
          end else begin
            addr_q <= addr_q + ADDR_W'(1);
          end
        end
      end
    end
  end

  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign busy_o      = (state_q == LOAD);
  assign done_o      = (state_q == DONE);
  assign error_o     = (state_q == ERR);

endmodule

`default_nettype wire

// File: tb/tb_instr_encode_loader.sv
// ============================================================================
// tb_instr_encode_loader : scoreboard bench for instr_encode_loader
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_instr_encode_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start0 = 1'b0, start1 = 1'b0;
  logic [7:0]  base_addr = '0;
  logic        in_valid = 1'b0;
  logic [2:0]  in_type = '0;
  logic [6:0]  in_opcode = '0;
  logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [2:0]  in_funct3 = '0;
  logic [6:0]  in_funct7 = '0;
  logic [11:0] in_imm = '0;
  logic        in_last = 1'b0;

  logic        rdy0, we0, busy0, done0, err0;
  logic [7:0]  addr0;
  logic [31:0] wd0;
  logic        rdy1, we1, busy1, done1, err1;
  logic [7:0]  addr1;
  logic [31:0] wd1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
    logic        done;
    logic        err;
    int          cyc;
  } ent_t;

  ent_t q0[$];
  ent_t q1[$];
  ent_t e0, e1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  instr_encode_loader #(.ADDR_W(8), .DEPTH(256)) u_dut (
    .clk(clk), .rst(rst), .start_i(start0), .base_addr_i(base_addr),
    .in_valid_i(in_valid), .in_ready_o(rdy0), .in_type_i(in_type),
    .in_opcode_i(in_opcode), .in_rd_i(in_rd), .in_rs1_i(in_rs1),
    .in_rs2_i(in_rs2), .in_funct3_i(in_funct3), .in_funct7_i(in_funct7),
    .in_imm_i(in_imm), .in_last_i(in_last), .mem_we_o(we0),
    .mem_addr_o(addr0), .mem_wdata_o(wd0), .busy_o(busy0),
    .done_o(done0), .error_o(err0)
  );

  instr_encode_loader #(.ADDR_W(8), .DEPTH(4)) u_small (
    .clk(clk), .rst(rst), .start_i(start1), .base_addr_i(base_addr),
    .in_valid_i(in_valid), .in_ready_o(rdy1), .in_type_i(in_type),
    .in_opcode_i(in_opcode), .in_rd_i(in_rd), .in_rs1_i(in_rs1),
    .in_rs2_i(in_rs2), .in_funct3_i(in_funct3), .in_funct7_i(in_funct7),
    .in_imm_i(in_imm), .in_last_i(in_last), .mem_we_o(we1),
    .mem_addr_o(addr1), .mem_wdata_o(wd1), .busy_o(busy1),
    .done_o(done1), .error_o(err1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Each write is matched against the oldest expected entry of its instance.
  always @(negedge clk) begin
    if (we0) begin
      if (q0.size() == 0) chk("we0_unexpected", 32'd1, 32'd0);
      else begin
        e0 = q0.pop_front();
        chk("addr0", {24'd0, addr0}, {24'd0, e0.addr});
        chk("data0", wd0, e0.data);
        chk("done0_at_we", {31'd0, done0}, {31'd0, e0.done});
        chk("err0_at_we", {31'd0, err0}, {31'd0, e0.err});
        chk("lat0", cyc, e0.cyc);
      end
    end
    if (we1) begin
      if (q1.size() == 0) chk("we1_unexpected", 32'd1, 32'd0);
      else begin
        e1 = q1.pop_front();
        chk("addr1", {24'd0, addr1}, {24'd0, e1.addr});
        chk("data1", wd1, e1.data);
        chk("done1_at_we", {31'd0, done1}, {31'd0, e1.done});
        chk("err1_at_we", {31'd0, err1}, {31'd0, e1.err});
        chk("lat1", cyc, e1.cyc);
      end
    end
  end

  // All tasks start and end at posedge+1.
  task automatic do_start(input bit sel, input logic [7:0] base);
    base_addr = base;
    if (sel) start1 = 1'b1; else start0 = 1'b1;
    @(negedge clk);
    chk("ready_in_start", {31'd0, sel ? rdy1 : rdy0}, 32'd0);
    @(posedge clk); #1;
    start0 = 1'b0;
    start1 = 1'b0;
    chk("busy_after_start", {31'd0, sel ? busy1 : busy0}, 32'd1);
  endtask

  task automatic drive(input logic [2:0] t, input logic [6:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [11:0] imm, input logic last);
    in_type = t; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_last = last;
    in_valid = 1'b1;
  endtask

  task automatic send(input bit sel, input bit push, input logic [7:0] ea,
                      input logic [31:0] ed, input logic edone, input logic eerr);
    ent_t e;
    bit   ok;
    ok = 1'b0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (sel ? rdy1 : rdy0) ok = 1'b1;
    end
    if (!ok) begin
      chk("handshake_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (push) begin
        e.addr = ea; e.data = ed; e.done = edone; e.err = eerr; e.cyc = cyc;
        if (sel) q1.push_back(e); else q0.push_back(e);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);
    chk("rst_ready", {31'd0, rdy0}, 32'd0);
    chk("rst_we", {31'd0, we0}, 32'd0);
    chk("rst_status", {29'd0, busy0, done0, err0}, 32'd0);
    chk("rst_addr_data", wd0 | {24'd0, addr0}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Session 1: I then S, base 0
    do_start(1'b0, 8'h00);
    drive(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 12'd5, 1'b0);
    send(1'b0, 1'b1, 8'h00, 32'h00500093, 1'b0, 1'b0);
    drive(3'd2, 7'h23, 5'd0, 5'd0, 5'd2, 3'd2, 7'd0, 12'd8, 1'b1);
    send(1'b0, 1'b1, 8'h01, 32'h00202423, 1'b1, 1'b0);
    @(negedge clk);
    chk("done_level_s1", {31'd0, done0}, 32'd1);
    @(posedge clk); #1;

    // Session 2: R, SB, UJ back-to-back at base 0x10
    do_start(1'b0, 8'h10);
    drive(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 12'hABC, 1'b0);
    send(1'b0, 1'b1, 8'h10, 32'h002081B3, 1'b0, 1'b0);
    drive(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 12'hFFE, 1'b0);
    send(1'b0, 1'b1, 8'h11, 32'hFE208F63, 1'b0, 1'b0);
    drive(3'd4, 7'h6F, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 12'h010, 1'b1);
    send(1'b0, 1'b1, 8'h12, 32'h0100006F, 1'b1, 1'b0);
    @(posedge clk); #1;

    // Overflow on the DEPTH=4 instance
    do_start(1'b1, 8'd2);
    drive(3'd2, 7'h23, 5'd0, 5'd1, 5'd4, 3'd0, 7'd0, 12'h03F, 1'b0);
    send(1'b1, 1'b1, 8'd2, 32'h02408FA3, 1'b0, 1'b0);
    drive(3'd1, 7'h13, 5'd9, 5'd0, 5'd0, 3'd0, 7'd0, 12'hFFF, 1'b0);
    send(1'b1, 1'b1, 8'd3, 32'hFFF00493, 1'b0, 1'b1);
    drive(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 12'h001, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ovf_ready_low", {31'd0, rdy1}, 32'd0);
      chk("ovf_error", {31'd0, err1}, 32'd1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;

    // Illegal type as second bundle
    do_start(1'b0, 8'h40);
    drive(3'd1, 7'h03, 5'd2, 5'd3, 5'd0, 3'd2, 7'd0, 12'h800, 1'b0);
    send(1'b0, 1'b1, 8'h40, 32'h8001A103, 1'b0, 1'b0);
    drive(3'd6, 7'h33, 5'd1, 5'd1, 5'd1, 3'd1, 7'd1, 12'h111, 1'b0);
    send(1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk("illegal_error", {31'd0, err0}, 32'd1);
    chk("illegal_no_we", {31'd0, we0}, 32'd0);
    @(posedge clk); #1;

    // start mid-session while in_valid is held
    do_start(1'b0, 8'h30);
    drive(3'd0, 7'h33, 5'd5, 5'd6, 5'd7, 3'd1, 7'h20, 12'hABC, 1'b0);
    send(1'b0, 1'b1, 8'h30, 32'h407312B3, 1'b0, 1'b0);
    drive(3'd4, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 12'h7FF, 1'b1);
    do_start(1'b0, 8'h20);
    send(1'b0, 1'b1, 8'h20, 32'h7FF0006F, 1'b1, 1'b0);
    @(posedge clk); #1;

    // rst in the cycle after a handshake drops the pending write
    do_start(1'b0, 8'h50);
    drive(3'd1, 7'h13, 5'd4, 5'd4, 5'd0, 3'd0, 7'd0, 12'h123, 1'b0);
    send(1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_we", {31'd0, we0}, 32'd0);
    chk("rst_mid_status", {29'd0, busy0, done0, err0}, 32'd0);
    chk("rst_mid_ready", {31'd0, rdy0}, 32'd0);
    chk("rst_mid_addr_data", wd0 | {24'd0, addr0}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_ready", {31'd0, rdy0}, 32'd0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    chk("q0_drained", q0.size(), 32'd0);
    chk("q1_drained", q1.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
